// File: rtl/updown_count_checker.sv
// Protocol observer for an up/down counter: judges every sampled step against the
// commanded direction, tracks lock, and reports errors and wrap-around events.
module updown_count_checker #(
  parameter int WIDTH     = 4,
  parameter int LOCK_N    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_down,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 dir,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_up,
  output logic                 wrap_down
);

  localparam int MW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_e;

  state_e                state_q, state_d;
  logic [MW-1:0]         match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0]      prev_count_q;
  logic                  prev_dir_q;
  logic                  locked_q, locked_d;
  logic                  dir_q, dir_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic                  wrap_up_q, wrap_up_d;
  logic                  wrap_down_q, wrap_down_d;

  logic [WIDTH-1:0]      expected;
  logic                  match;
  logic                  new_err;
  logic [MW-1:0]         match_inc;
  logic [ERR_CNT_W-1:0]  err_inc;

  assign expected  = prev_dir_q ? prev_count_q + WIDTH'(1) : prev_count_q - WIDTH'(1);
  assign match     = (count == expected);
  assign match_inc = match_cnt_q + MW'(1);
  assign err_inc   = (err_count_q == '1) ? err_count_q : err_count_q + ERR_CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      match_cnt_q  <= '0;
      prev_count_q <= '0;
      prev_dir_q   <= 1'b0;
      locked_q     <= 1'b0;
      dir_q        <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_up_q    <= 1'b0;
      wrap_down_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      prev_count_q <= count;
      prev_dir_q   <= up_down;
      locked_q     <= locked_d;
      dir_q        <= dir_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wrap_up_q    <= wrap_up_d;
      wrap_down_q  <= wrap_down_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    dir_d       = dir_q;
    new_err     = 1'b0;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;

    case (state_q)
      IDLE: begin
        state_d     = ACQ;
        match_cnt_d = '0;
      end
      ACQ: begin
        if (match) begin
          if (match_inc == MW'(LOCK_N)) begin
            state_d     = LOCK;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_inc;
          end
        end else begin
          match_cnt_d = '0;
        end
      end
      LOCK: begin
        if (!match) begin
          new_err     = 1'b1;
          match_cnt_d = '0;
          state_d     = ACQ;
        end
      end
      default: begin
        state_d     = IDLE;
        match_cnt_d = '0;
      end
    endcase

    // The matched step was steered by the direction sampled on the previous edge.
    if (match && (state_q == ACQ || state_q == LOCK)) begin
      dir_d       = prev_dir_q;
      wrap_up_d   = prev_dir_q  && (prev_count_q == '1);
      wrap_down_d = !prev_dir_q && (prev_count_q == '0);
    end
  end

  always_comb begin
    locked_d     = (state_d == LOCK);
    err_pulse_d  = new_err;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    // A fresh error beats a simultaneous clear, leaving a count of one.
    if (new_err) begin
      err_sticky_d = 1'b1;
      err_count_d  = clr_err ? ERR_CNT_W'(1) : err_inc;
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  assign locked     = locked_q;
  assign dir        = dir_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_down  = wrap_down_q;

endmodule

// File: tb/tb_updown_count_checker.sv
// Directed bench for updown_count_checker: each scenario drives samples and compares
// the packed output vector {locked,dir,err_pulse,err_sticky,err_count[1:0],wrap_up,wrap_down}.
module tb_updown_count_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_down = 1'b0;
  logic [3:0] count = '0;
  logic       clr_err = 1'b0;
  logic       locked, dir, err_pulse, err_sticky, wrap_up, wrap_down;
  logic [1:0] err_count;
  logic [7:0] obs;

  int errors = 0;
  int checks = 0;

  updown_count_checker #(.WIDTH(4), .LOCK_N(4), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .up_down(up_down), .count(count), .clr_err(clr_err),
    .locked(locked), .dir(dir), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .wrap_up(wrap_up), .wrap_down(wrap_down)
  );

  always #5 clk = ~clk;

  assign obs = {locked, dir, err_pulse, err_sticky, err_count, wrap_up, wrap_down};

  task automatic step(input logic [3:0] c, input logic ud, input logic clr);
    @(negedge clk);
    count = c; up_down = ud; clr_err = clr;
    @(posedge clk); #1;
  endtask

  task automatic release_step(input logic [3:0] c, input logic ud);
    @(negedge clk);
    rst = 1'b0; count = c; up_down = ud; clr_err = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic assert_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      count = 4'($urandom); up_down = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs, 8'h00);
      end
    end
  endtask

  task automatic test_down();
    logic [3:0] seq [5] = '{15, 14, 13, 12, 11};
    logic [7:0] exp [5] = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h80};
    release_step(4'd0, 1'b0);
    checks++;
    if (obs !== 8'h00) begin
      errors++; $display("FAIL down_idle got=%h want=%h", obs, 8'h00);
    end
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b0, 1'b0);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL down[%0d] count=%0d got=%h want=%h", i, seq[i], obs, exp[i]);
      end
    end
  endtask

  task automatic test_reversal();
    logic [3:0] seq [8] = '{10, 11, 12, 13, 14, 15, 0, 1};
    logic [7:0] exp [8] = '{8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC2, 8'hC0};
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b1, 1'b0);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL reversal[%0d] count=%0d got=%h want=%h", i, seq[i], obs, exp[i]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] seq [9] = '{2, 3, 4, 5, 9, 10, 11, 12, 13};
    logic [7:0] exp [9] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h74, 8'h54, 8'h54, 8'h54, 8'hD4};
    for (int i = 0; i < 9; i++) begin
      step(seq[i], 1'b1, 1'b0);
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL glitch[%0d] count=%0d got=%h want=%h", i, seq[i], obs, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] sat_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [3:0] cur;
    logic [7:0] exp;
    int         npulse;
    assert_rst();
    release_step(4'd0, 1'b1);
    for (int i = 1; i <= 4; i++) step(4'(i), 1'b1, 1'b0);
    cur = 4'd4;
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      cur = cur + 4'd3;
      step(cur, 1'b1, 1'b0);
      npulse += int'(err_pulse);
      exp = {4'b0111, sat_tab[k], 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL sat_err[%0d] got=%h want=%h", k, obs, exp);
      end
      for (int j = 0; j < 4; j++) begin
        cur = cur + 4'd1;
        step(cur, 1'b1, 1'b0);
        npulse += int'(err_pulse);
      end
      checks++;
      if (locked !== 1'b1) begin
        errors++; $display("FAIL sat_relock[%0d] got=%b want=1", k, locked);
      end
    end
    checks++;
    if (npulse !== 5) begin
      errors++; $display("FAIL sat_pulses got=%0d want=5", npulse);
    end
    // cur is 7 here; walk up to 14, then jump across the boundary to 1 with clr_err.
    for (int j = 8; j <= 14; j++) step(4'(j), 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b1);
    checks++;
    if (obs !== 8'h74) begin
      errors++; $display("FAIL clr_vs_err got=%h want=%h", obs, 8'h74);
    end
    step(4'd2, 1'b1, 1'b1);
    checks++;
    if (obs !== 8'h40) begin
      errors++; $display("FAIL clr_alone got=%h want=%h", obs, 8'h40);
    end
    step(4'd3, 1'b1, 1'b0);
    step(4'd4, 1'b1, 1'b0);
    step(4'd5, 1'b1, 1'b0);
    checks++;
    if (obs !== 8'hC0) begin
      errors++; $display("FAIL clr_relock got=%h want=%h", obs, 8'hC0);
    end
    step(4'd6, 1'b1, 1'b1);
    checks++;
    if (obs !== 8'hC0) begin
      errors++; $display("FAIL clr_keeps_lock got=%h want=%h", obs, 8'hC0);
    end
  endtask

  task automatic test_noise();
    logic [3:0] noise [4] = '{3, 12, 3, 9};
    logic [3:0] clean [5] = '{4, 5, 6, 7, 8};
    logic [7:0] cexp  [5] = '{8'h00, 8'h40, 8'h40, 8'h40, 8'hC0};
    assert_rst();
    release_step(4'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(noise[i], 1'b1, 1'b0);
      checks++;
      if (obs !== 8'h00) begin
        errors++; $display("FAIL noise[%0d] count=%0d got=%h want=%h", i, noise[i], obs, 8'h00);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(clean[i], 1'b1, 1'b0);
      checks++;
      if (obs !== cexp[i]) begin
        errors++; $display("FAIL clean[%0d] count=%0d got=%h want=%h", i, clean[i], obs, cexp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++; $display("FAIL async_rst got=%h want=%h", obs, 8'h00);
    end
    @(negedge clk);
    release_step(4'd0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(4'(i), 1'b1, 1'b0);
      checks++;
      if (obs !== ((i == 4) ? 8'hC0 : 8'h40)) begin
        errors++;
        $display("FAIL reacq[%0d] got=%h want=%h", i, obs, (i == 4) ? 8'hC0 : 8'h40);
      end
    end
  endtask

  initial begin
    test_reset();
    test_down();
    test_reversal();
    test_glitch();
    test_saturation();
    test_noise();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_count_checker.md
Name: updown_count_checker

Overview:
- Observer for the up/down counter: samples the counter's count output and its up_down control every clock, and checks that each step is exactly +1 or -1 (mod 2^WIDTH) in the commanded direction.
- Reports lock status, step errors, wrap-around events and the current direction.
- Sits beside the counter in the system and in benches as a protocol checker, sharing the counter's clk and rst.

Parameters:
- WIDTH, 4, width of the observed count.
- LOCK_N, 4, consecutive correct steps required to declare lock (1..15).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- up_down  in  1  counter direction control as driven to the counter; 1 = count up, 0 = count down.
- count  in  WIDTH  counter output being observed.
- clr_err  in  1  synchronous clear of err_sticky and err_count.
- locked  out  1  high while in LOCK state.
- dir  out  1  direction of the last correctly matched step.
- err_pulse  out  1  one-cycle pulse on a mismatch detected in LOCK.
- err_sticky  out  1  set on any err_pulse; cleared only by clr_err or rst.
- err_count  out  ERR_CNT_W  number of errors, saturating at all-ones.
- wrap_up  out  1  one-cycle pulse on a matched step from max to 0.
- wrap_down  out  1  one-cycle pulse on a matched step from 0 to max.

Behaviour:
- Reset: rst=1 asynchronously forces state IDLE, match_cnt=0, prev_count=0, prev_dir=0, and every output to 0.
- Sampling model: each rising edge captures count (the pre-update value) and up_down (the value steering that edge).
- Expected value: the sample at edge k+1 must equal prev_count+1 if prev_dir=1, or prev_count-1 if prev_dir=0. Arithmetic is modulo 2^WIDTH.
- Every edge outside reset: prev_count<=count and prev_dir<=up_down.
- All outputs are registered. They change at the edge that captures the judged sample and are visible the following cycle. Pulses are exactly one cycle wide.
- IDLE:
  - First edge after rst deasserts captures history only.
  - Goes to ACQ. No compare is made.
- ACQ:
  - Match: match_cnt++. When match_cnt reaches LOCK_N, go to LOCK, set locked=1, and clear match_cnt.
  - Mismatch: match_cnt=0, stay in ACQ, resync to the observed value. No error is flagged.
- LOCK:
  - Match: stay in LOCK.
  - Mismatch: err_pulse=1, err_sticky=1, err_count++ (saturating), locked=0, match_cnt=0, go to ACQ.
- dir is updated only on matched steps in ACQ or LOCK.
- wrap_up / wrap_down:
  - Fire only on matched steps in ACQ or LOCK.
  - A mismatching jump that happens to cross the boundary does not pulse.
- Direction change is legal on any cycle. The step after the change is judged against the new up_down value and is not an error.
- clr_err in the same cycle as a new error: the error wins. Result is err_sticky=1 and err_count=1.
- clr_err alone: err_sticky=0 and err_count=0 next cycle. locked is unaffected.
- Saturation: when err_count is at all-ones, further errors still pulse err_pulse, but the count holds.
- rst asserted mid-LOCK: all outputs drop to 0 immediately (asynchronous). After release, re-acquisition takes 1 + LOCK_N edges.

Test Plan (clk period 10 ns, rst high 0–50 ns):
1. Reset: rst=1 with count toggling randomly -> all outputs stay 0. Reassert rst mid-LOCK -> locked drops to 0 within the same cycle, with no clock edge required.
2. Down count: up_down=0, count 0,15,14,13,12,11 -> wrap_down pulses once, one cycle after 15 is sampled. locked=1 after the 5th sample (LOCK_N=4). dir=0. No errors.
3. Reversal: while locked and counting down, set up_down=1 -> counter turns around (e.g. 11,10,11,12). No err_pulse, dir becomes 1. Continuing 14,15,0 -> wrap_up pulses once.
4. Glitch: locked, counting up, force count 5 then 9 -> err_pulse for 1 cycle, err_count=1, err_sticky=1, locked=0. Resumes 10,11,12,13 -> locked=1 again after 4 matches.
5. Saturation and clear, ERR_CNT_W=2: inject 5 errors -> err_count stays at 3 and err_pulse fires 5 times. Assert clr_err on the same cycle as a 6th error -> err_count=1, err_sticky=1. clr_err alone -> both 0.
6. Acquisition noise: random count values before a valid sequence -> no err_pulse and locked=0. After 5 clean consecutive samples -> locked=1.
